// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI memory path: bus width defaults and the
// bridge state encoding.
`ifndef SPI_MEM_ADDR_WIDTH
`define SPI_MEM_ADDR_WIDTH 16
`endif
`ifndef SPI_MEM_DATA_WIDTH
`define SPI_MEM_DATA_WIDTH 8
`endif

package spi_mem_pkg;

  localparam int SPI_MEM_ADDR_W      = `SPI_MEM_ADDR_WIDTH;
  localparam int SPI_MEM_DATA_W      = `SPI_MEM_DATA_WIDTH;
  localparam int SPI_MEM_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    BRIDGE_IDLE  = 2'd0,
    BRIDGE_READ  = 2'd1,
    BRIDGE_WRITE = 2'd2
  } bridge_state_t;

endpackage

// File: rtl/spi_strobe_sync.sv
// Brings one asynchronous strobe into the clk domain and produces registered
// single-cycle rise/fall pulses aligned with the delayed level.
module spi_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
      hist  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_in};
      hist  <= chain[SYNC_STAGES-1];
      rise  <= chain[SYNC_STAGES-1] & ~hist;
      fall  <= ~chain[SYNC_STAGES-1] & hist;
    end
  end

  // hist lines up with the registered pulses, so level and edge agree
  assign level = hist;

endmodule

// File: rtl/spi_mem_bridge.sv
// Moves SPI-slave (SCK domain) read/write strobes into clk and runs each one
// as a req/ack transaction on the system memory port.
//
// state        | meaning
// BRIDGE_IDLE  | no access in flight, new strobe events accepted
// BRIDGE_READ  | mem_rd held until mem_ack, then mem_rdata -> spi_rdata
// BRIDGE_WRITE | mem_wr held until mem_ack
module spi_mem_bridge
  import spi_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = SPI_MEM_ADDR_W,
  parameter int DATA_WIDTH  = SPI_MEM_DATA_W,
  parameter int SYNC_STAGES = SPI_MEM_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] spi_addr,
  input  logic [DATA_WIDTH-1:0] spi_wdata,
  input  logic                  spi_rd,
  input  logic                  spi_wr,
  output logic [DATA_WIDTH-1:0] spi_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  overrun,
  input  logic                  overrun_clear,
  output logic                  busy
);

  bridge_state_t state_q, state_d;

  logic                  rd_level, rd_rise, rd_fall;
  logic                  wr_level, wr_rise, wr_fall;
  logic                  start_rd, start_wr, drop_evt;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic                  unused_sync;

  spi_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
    .clk     (clk),
    .reset   (reset),
    .async_in(spi_rd),
    .level   (rd_level),
    .rise    (rd_rise),
    .fall    (rd_fall)
  );

  spi_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
    .clk     (clk),
    .reset   (reset),
    .async_in(spi_wr),
    .level   (wr_level),
    .rise    (wr_rise),
    .fall    (wr_fall)
  );

  assign unused_sync = ^{rd_level, rd_fall, wr_level};

  // A write outranks a simultaneous read; the read then counts as dropped.
  always_comb begin
    state_d  = state_q;
    start_rd = 1'b0;
    start_wr = 1'b0;
    drop_evt = 1'b0;
    case (state_q)
      BRIDGE_IDLE: begin
        if (wr_fall) begin
          start_wr = 1'b1;
          drop_evt = rd_rise;
          state_d  = BRIDGE_WRITE;
        end else if (rd_rise) begin
          start_rd = 1'b1;
          state_d  = BRIDGE_READ;
        end
      end
      BRIDGE_READ, BRIDGE_WRITE: begin
        drop_evt = rd_rise | wr_fall;
        if (mem_ack) state_d = BRIDGE_IDLE;
      end
      default: state_d = BRIDGE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= BRIDGE_IDLE;
      addr_hold <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      spi_rdata <= '0;
      overrun   <= 1'b0;
    end else begin
      state_q <= state_d;
      // the SPI address has already advanced by the time wr falls
      if (wr_rise) addr_hold <= spi_addr;
      if (start_rd) begin
        mem_addr <= spi_addr;
      end else if (start_wr) begin
        mem_addr  <= addr_hold;
        mem_wdata <= spi_wdata;
      end
      if (state_q == BRIDGE_READ && mem_ack) spi_rdata <= mem_rdata;
      if (drop_evt) overrun <= 1'b1;
      else if (overrun_clear) overrun <= 1'b0;
    end
  end

  assign mem_rd = (state_q == BRIDGE_READ);
  assign mem_wr = (state_q == BRIDGE_WRITE);
  assign busy   = (state_q != BRIDGE_IDLE);

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Directed plus randomized bench for spi_mem_bridge against a transaction-level
// memory model and expected-memory image.
module tb_spi_mem_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] spi_addr = '0;
  logic [7:0]  spi_wdata = '0;
  logic        spi_rd = 1'b0;
  logic        spi_wr = 1'b0;
  logic [7:0]  spi_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        overrun;
  logic        overrun_clear = 1'b0;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  int ack_wait = 0;
  bit ack_hold = 1'b0;
  int req_cycles = 0;

  logic [7:0] mem_model [65536];
  logic [7:0] ref_mem   [65536];

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  data;
    int          len;
    bit          ok;
  } txn_t;
  txn_t obs_q[$];

  spi_mem_bridge dut (
    .clk          (clk),
    .reset        (reset),
    .spi_addr     (spi_addr),
    .spi_wdata    (spi_wdata),
    .spi_rd       (spi_rd),
    .spi_wr       (spi_wr),
    .spi_rdata    (spi_rdata),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .overrun      (overrun),
    .overrun_clear(overrun_clear),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // memory responder: ack after ack_wait request cycles unless held off
  assign mem_ack   = (mem_rd | mem_wr) && !ack_hold && (req_cycles >= ack_wait);
  assign mem_rdata = mem_model[mem_addr];

  always @(posedge clk) req_cycles <= (mem_rd | mem_wr) ? req_cycles + 1 : 0;

  // transaction monitor: one record per completed request
  int          cur_len = 0;
  logic [15:0] st_addr;
  logic [7:0]  st_wdata, st_rdata;
  bit          st_ok;
  always @(negedge clk) begin
    if (reset) begin
      cur_len = 0;
    end else if (mem_rd | mem_wr) begin
      if (cur_len == 0) begin
        st_addr  = mem_addr;
        st_wdata = mem_wdata;
        st_rdata = spi_rdata;
        st_ok    = 1'b1;
      end
      cur_len++;
      if (mem_addr !== st_addr || (mem_wr && mem_wdata !== st_wdata) ||
          (mem_rd && mem_wr) || !busy || spi_rdata !== st_rdata)
        st_ok = 1'b0;
      if (mem_ack) begin
        obs_q.push_back('{wr: mem_wr, addr: mem_addr,
                          data: mem_wr ? mem_wdata : mem_rdata,
                          len: cur_len, ok: st_ok});
        if (mem_wr) mem_model[mem_addr] = mem_wdata;
        cur_len = 0;
      end
    end else begin
      cur_len = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_txn(input string tag, input bit wr, input logic [15:0] a,
                            input logic [7:0] d, input int len);
    txn_t t;
    check({tag, "_count"}, obs_q.size(), 32'd1 <= obs_q.size() ? obs_q.size() : 1);
    if (obs_q.size() == 0) return;
    t = obs_q.pop_front();
    check({tag, "_kind"}, {31'd0, t.wr}, {31'd0, wr});
    check({tag, "_addr"}, {16'd0, t.addr}, {16'd0, a});
    check({tag, "_data"}, {24'd0, t.data}, {24'd0, d});
    check({tag, "_stable"}, {31'd0, t.ok}, 32'd1);
    if (len >= 0) check({tag, "_len"}, t.len, len);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) check({tag, "_idle_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_read(input logic [15:0] a, input int w, input string tag);
    ack_wait = w;
    spi_addr = a;
    spi_rd   = 1'b1;
    repeat (12) @(negedge clk);
    spi_rd = 1'b0;
    wait_idle(tag);
    repeat (4) @(negedge clk);
    expect_txn(tag, 1'b0, a, ref_mem[a], w + 1);
    check({tag, "_spi_rdata"}, {24'd0, spi_rdata}, {24'd0, ref_mem[a]});
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int half, input int w);
    ack_wait  = w;
    spi_addr  = a;
    spi_wdata = 8'h00;
    spi_wr    = 1'b1;
    repeat (half / 2) @(negedge clk);
    spi_wdata = d;
    repeat (half - half / 2) @(negedge clk);
    spi_addr = a + 16'd1;
    spi_wr   = 1'b0;
    repeat (half) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic [7:0]  d, old;
    int          rd_hi;
    int          w;

    for (int i = 0; i < 65536; i++) begin
      d = 8'($urandom);
      mem_model[i] = d;
      ref_mem[i]   = d;
    end
    mem_model[16'h0123] = 8'hA5;
    ref_mem[16'h0123]   = 8'hA5;

    repeat (3) @(negedge clk);
    check("rst_spi_rdata", {24'd0, spi_rdata}, 32'd0);
    check("rst_mem_addr",  {16'd0, mem_addr},  32'd0);
    check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    check("rst_mem_rd",    {31'd0, mem_rd},    32'd0);
    check("rst_mem_wr",    {31'd0, mem_wr},    32'd0);
    check("rst_overrun",   {31'd0, overrun},   32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // zero-wait read latency, counting the edge that first samples spi_rd=1 as edge 1
    ack_wait = 0;
    spi_addr = 16'h0123;
    spi_rd   = 1'b1;
    rd_hi    = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      rd_hi += int'(mem_rd);
      if (k == 4) begin
        check("lat_mem_rd_e4",   {31'd0, mem_rd},    32'd1);
        check("lat_mem_addr_e4", {16'd0, mem_addr},  32'h0123);
        check("lat_rdata_e4",    {24'd0, spi_rdata}, 32'd0);
      end
      if (k == 5) begin
        check("lat_rdata_e5",  {24'd0, spi_rdata}, 32'hA5);
        check("lat_mem_rd_e5", {31'd0, mem_rd},    32'd0);
      end
    end
    spi_rd = 1'b0;
    repeat (4) @(negedge clk);
    check("lat_rd_cycles", rd_hi, 1);
    expect_txn("lat_txn", 1'b0, 16'h0123, 8'hA5, 1);

    // write ordering: address from wr rise, data from wr fall
    do_write(16'h0040, 8'h3C, 20, 0);
    wait_idle("wr");
    expect_txn("wr_txn", 1'b1, 16'h0040, 8'h3C, 1);
    ref_mem[16'h0040] = 8'h3C;
    check("wr_extra", obs_q.size(), 0);

    // wait states
    a = 16'($urandom);
    do_read(a, 3, "wait");

    // overrun: write arrives while a read is stalled
    ack_hold = 1'b1;
    ack_wait = 0;
    a = 16'($urandom_range(0, 255)) + 16'h3000;
    spi_addr = a;
    spi_rd   = 1'b1;
    repeat (10) @(negedge clk);
    spi_rd = 1'b0;
    check("ovr_pending_rd", {31'd0, mem_rd}, 32'd1);
    check("ovr_busy",       {31'd0, busy},   32'd1);
    repeat (3) @(negedge clk);
    do_write(16'h5555, 8'h77, 10, 0);
    check("ovr_set",   {31'd0, overrun}, 32'd1);
    check("ovr_no_wr", {31'd0, mem_wr},  32'd0);
    ack_hold = 1'b0;
    wait_idle("ovr");
    repeat (2) @(negedge clk);
    expect_txn("ovr_txn", 1'b0, a, ref_mem[a], -1);
    check("ovr_dropped_wr", obs_q.size(), 0);
    check("ovr_rdata", {24'd0, spi_rdata}, {24'd0, ref_mem[a]});
    check("ovr_sticky", {31'd0, overrun}, 32'd1);
    overrun_clear = 1'b1;
    @(negedge clk);
    overrun_clear = 1'b0;
    check("ovr_cleared", {31'd0, overrun}, 32'd0);

    // rd rise and wr fall seen in the same cycle: write wins, read dropped
    a = 16'h0A0A;
    d = 8'($urandom);
    ack_wait  = 0;
    spi_addr  = a;
    spi_wdata = 8'h00;
    spi_wr    = 1'b1;
    repeat (10) @(negedge clk);
    spi_wdata = d;
    repeat (10) @(negedge clk);
    spi_wr = 1'b0;
    spi_rd = 1'b1;
    repeat (12) @(negedge clk);
    spi_rd = 1'b0;
    wait_idle("coll");
    repeat (3) @(negedge clk);
    expect_txn("coll_txn", 1'b1, a, d, 1);
    ref_mem[a] = d;
    check("coll_no_rd", obs_q.size(), 0);
    check("coll_overrun", {31'd0, overrun}, 32'd1);
    overrun_clear = 1'b1;
    @(negedge clk);
    overrun_clear = 1'b0;

    // reset in the middle of a read
    ack_hold = 1'b1;
    spi_addr = 16'($urandom);
    spi_rd   = 1'b1;
    repeat (8) @(negedge clk);
    spi_rd = 1'b0;
    repeat (4) @(negedge clk);
    check("rstmid_pending", {31'd0, mem_rd}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_mem_rd",  {31'd0, mem_rd},    32'd0);
    check("rstmid_rdata",   {24'd0, spi_rdata}, 32'd0);
    check("rstmid_busy",    {31'd0, busy},      32'd0);
    check("rstmid_overrun", {31'd0, overrun},   32'd0);
    reset = 1'b0;
    ack_hold = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid_no_txn", obs_q.size(), 0);
    do_read(16'h7FFF, 0, "after_rst");

    // back-to-back writes at a 20-cycle SCK half period
    for (int i = 0; i < 4; i++) begin
      ref_mem[16'h0100] = ref_mem[16'h0100];
      d = 8'($urandom);
      a = 16'h00FE + 16'(i);
      do_write(a, d, 20, 0);
      ref_mem[a] = d;
    end
    wait_idle("b2b");
    for (int i = 0; i < 4; i++) begin
      a = 16'h00FE + 16'(i);
      expect_txn("b2b_txn", 1'b1, a, ref_mem[a], 1);
    end
    check("b2b_overrun", {31'd0, overrun}, 32'd0);

    // randomized mix over a small window so reads hit earlier writes
    for (int i = 0; i < 24; i++) begin
      a = 16'h2000 + 16'($urandom_range(0, 7));
      w = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = 8'($urandom);
        do_write(a, d, 12, w);
        wait_idle("rnd_wr");
        expect_txn("rnd_wr_txn", 1'b1, a, d, w + 1);
        ref_mem[a] = d;
      end else begin
        old = spi_rdata;
        do_read(a, w, "rnd_rd");
      end
    end
    for (int i = 0; i < 8; i++) begin
      a = 16'h2000 + 16'(i);
      do_read(a, 0, "readback");
    end
    check("final_overrun", {31'd0, overrun}, 32'd0);
    check("final_no_extra", obs_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
